// File: rtl/dummy_accelerator_issue_queue_if.sv
// Core-to-accelerator issue port bundle: core request side, accelerator side, flush/done and status.
// "slave" is the queue's view; "master" is the surrounding core/accelerator view.
interface dummy_accelerator_issue_queue_if #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned CTL_W        = 8,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned MAX_INFLIGHT = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

    logic             flush_i;
    logic             core_valid_i;
    logic             core_ready_o;
    logic [XLEN-1:0]  core_rs1_i;
    logic [XLEN-1:0]  core_rs2_i;
    logic [CTL_W-1:0] core_ctl_i;
    logic [TAG_W-1:0] core_tag_i;
    logic             acc_valid_o;
    logic             acc_ready_i;
    logic [XLEN-1:0]  acc_rs1_o;
    logic [XLEN-1:0]  acc_rs2_o;
    logic [CTL_W-1:0] acc_ctl_o;
    logic [TAG_W-1:0] acc_tag_o;
    logic             acc_done_i;
    logic [CNT_W-1:0] count_o;
    logic [INF_W-1:0] inflight_o;
    logic             empty_o;
    logic             full_o;

    modport slave (
        input  flush_i, core_valid_i, core_rs1_i, core_rs2_i, core_ctl_i, core_tag_i,
               acc_ready_i, acc_done_i,
        output core_ready_o, acc_valid_o, acc_rs1_o, acc_rs2_o, acc_ctl_o, acc_tag_o,
               count_o, inflight_o, empty_o, full_o
    );

    modport master (
        output flush_i, core_valid_i, core_rs1_i, core_rs2_i, core_ctl_i, core_tag_i,
               acc_ready_i, acc_done_i,
        input  core_ready_o, acc_valid_o, acc_rs1_o, acc_rs2_o, acc_ctl_o, acc_tag_o,
               count_o, inflight_o, empty_o, full_o
    );
endinterface

// File: rtl/dummy_accelerator_issue_queue.sv
// Circular request FIFO in front of the dummy accelerator, with a cap on requests
// issued to the accelerator but not yet completed.
module dummy_accelerator_issue_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned CTL_W        = 8,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    dummy_accelerator_issue_queue_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [CTL_W-1:0] ctl;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;
    logic [INF_W-1:0] r_inflight;

    logic   w_full;
    logic   w_empty;
    logic   w_acc_valid;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    // Handshake outputs derive from registered state only
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_acc_valid = !w_empty && (r_inflight < INF_W'(MAX_INFLIGHT));
    assign w_push      = bus.core_valid_i && !w_full;
    assign w_pop       = w_acc_valid && bus.acc_ready_i;
    assign w_head      = r_mem[r_rp];

    assign bus.core_ready_o = !w_full;
    assign bus.acc_valid_o  = w_acc_valid;
    assign bus.acc_rs1_o    = w_head.rs1;
    assign bus.acc_rs2_o    = w_head.rs2;
    assign bus.acc_ctl_o    = w_head.ctl;
    assign bus.acc_tag_o    = w_head.tag;
    assign bus.count_o      = r_count;
    assign bus.inflight_o   = r_inflight;
    assign bus.empty_o      = w_empty;
    assign bus.full_o       = w_full;

    // Entry storage; a push in a flush cycle is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !bus.flush_i) begin
            r_mem[r_wp] <= {bus.core_rs1_i, bus.core_rs2_i, bus.core_ctl_i, bus.core_tag_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else if (bus.flush_i) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A done with nothing outstanding is dropped so the counter cannot underflow
            if (w_pop && !bus.acc_done_i) begin
                r_inflight <= r_inflight + INF_W'(1);
            end else if (!w_pop && bus.acc_done_i && (r_inflight != '0)) begin
                r_inflight <= r_inflight - INF_W'(1);
            end
        end
    end

    a_done_without_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.acc_done_i && !bus.flush_i && !w_pop && (r_inflight == '0)));

endmodule

// File: tb/tb_dummy_accelerator_issue_queue.sv
// Bench for the accelerator issue queue: directed vector table, reset/wrap sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_dummy_accelerator_issue_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXI  = 2;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   errors;

    dummy_accelerator_issue_queue_if #(.DEPTH(DEPTH), .XLEN(64), .CTL_W(8), .TAG_W(4),
                                       .MAX_INFLIGHT(MAXI)) bus ();

    dummy_accelerator_issue_queue #(.DEPTH(DEPTH), .XLEN(64), .CTL_W(8), .TAG_W(4),
                                    .MAX_INFLIGHT(MAXI)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       cv;
        logic [3:0] tag;
        logic       rdy;
        logic       done;
        logic       fl;
        int         e_cnt;
        int         e_inf;
        logic       e_val;
        logic [3:0] e_tag;
    } vec_t;

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [7:0]  ctl;
        logic [3:0]  tag;
    } ent_t;

    vec_t       tbl [34];
    ent_t       mq [$];
    int         m_inf;
    logic [3:0] dut_pops [$];
    int         max_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic cv, input int tag, input logic rdy, input logic done,
                                input logic fl, input int e_cnt, input int e_inf,
                                input logic e_val, input int e_tag);
        vec_t v;
        v.cv = cv; v.tag = 4'(tag); v.rdy = rdy; v.done = done; v.fl = fl;
        v.e_cnt = e_cnt; v.e_inf = e_inf; v.e_val = e_val; v.e_tag = 4'(e_tag);
        return v;
    endfunction

    task automatic drive(input logic cv, input ent_t e, input logic rdy, input logic dn,
                         input logic fl);
        bus.core_valid_i = cv;
        bus.core_rs1_i   = e.rs1;
        bus.core_rs2_i   = e.rs2;
        bus.core_ctl_i   = e.ctl;
        bus.core_tag_i   = e.tag;
        bus.acc_ready_i  = rdy;
        bus.acc_done_i   = dn;
        bus.flush_i      = fl;
    endtask

    task automatic check_model(input string tag);
        int n;
        logic exp_val;
        n = mq.size();
        exp_val = (n > 0) && (m_inf < int'(MAXI));
        chk({tag, "_count"}, 64'(bus.count_o), 64'(n));
        chk({tag, "_inflight"}, 64'(bus.inflight_o), 64'(m_inf));
        chk({tag, "_acc_valid"}, 64'(bus.acc_valid_o), 64'(exp_val));
        chk({tag, "_core_ready"}, 64'(bus.core_ready_o), 64'(n < int'(DEPTH)));
        chk({tag, "_empty"}, 64'(bus.empty_o), 64'(n == 0));
        chk({tag, "_full"}, 64'(bus.full_o), 64'(n == int'(DEPTH)));
        if (exp_val) begin
            chk({tag, "_rs1"}, bus.acc_rs1_o, mq[0].rs1);
            chk({tag, "_rs2"}, bus.acc_rs2_o, mq[0].rs2);
            chk({tag, "_ctl"}, 64'(bus.acc_ctl_o), 64'(mq[0].ctl));
            chk({tag, "_tag"}, 64'(bus.acc_tag_o), 64'(mq[0].tag));
        end
    endtask

    // One cycle against the reference model: FIFO as a queue, in-flight as an integer
    task automatic step(input string tag, input logic cv, input ent_t e, input logic rdy,
                        input logic dn, input logic fl);
        logic m_pop;
        logic m_push;
        drive(cv, e, rdy, dn, fl);
        m_pop  = (mq.size() > 0) && (m_inf < int'(MAXI)) && rdy;
        m_push = cv && (mq.size() < int'(DEPTH));
        if (bus.acc_valid_o && rdy) dut_pops.push_back(bus.acc_tag_o);
        @(posedge clk_i);
        if (fl) begin
            mq.delete();
            m_inf = 0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(e);
            if (m_pop && !dn) m_inf++;
            else if (!m_pop && dn && m_inf > 0) m_inf--;
        end
        #1;
        check_model(tag);
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.rs1 = {$urandom, $urandom};
        e.rs2 = {$urandom, $urandom};
        e.ctl = 8'($urandom);
        e.tag = 4'($urandom);
        return e;
    endfunction

    initial begin
        ent_t e;
        checks = 0;
        errors = 0;
        e = '{default: '0};
        drive(1'b0, e, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;

        tbl[0]  = mk(1, 3, 1, 0, 0, 1, 0, 1, 3);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 2, 0, 1, 0);
        tbl[5]  = mk(1, 2, 0, 0, 0, 3, 0, 1, 0);
        tbl[6]  = mk(1, 3, 0, 0, 0, 4, 0, 1, 0);
        tbl[7]  = mk(1, 4, 0, 0, 0, 4, 0, 1, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 3, 1, 1, 1);
        tbl[9]  = mk(0, 0, 1, 1, 0, 2, 1, 1, 2);
        tbl[10] = mk(0, 0, 1, 1, 0, 1, 1, 1, 3);
        tbl[11] = mk(0, 0, 1, 1, 0, 0, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 8, 0, 0, 0, 1, 0, 1, 8);
        tbl[14] = mk(1, 9, 0, 0, 0, 2, 0, 1, 8);
        tbl[15] = mk(1, 10, 0, 0, 0, 3, 0, 1, 8);
        tbl[16] = mk(0, 0, 1, 0, 0, 2, 1, 1, 9);
        tbl[17] = mk(0, 0, 1, 0, 0, 1, 2, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 0, 1, 2, 0, 0);
        tbl[19] = mk(0, 0, 1, 1, 0, 1, 1, 1, 10);
        tbl[20] = mk(0, 0, 1, 0, 0, 0, 2, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[23] = mk(1, 11, 0, 0, 0, 1, 0, 1, 11);
        tbl[24] = mk(1, 12, 0, 0, 0, 2, 0, 1, 11);
        tbl[25] = mk(1, 13, 1, 0, 0, 2, 1, 1, 12);
        tbl[26] = mk(0, 0, 1, 1, 0, 1, 1, 1, 13);
        tbl[27] = mk(1, 14, 0, 0, 0, 2, 1, 1, 13);
        tbl[28] = mk(1, 15, 1, 0, 0, 2, 2, 0, 0);
        tbl[29] = mk(1, 1, 0, 0, 0, 3, 2, 0, 0);
        tbl[30] = mk(1, 2, 1, 1, 1, 0, 0, 0, 0);
        tbl[31] = mk(1, 5, 0, 0, 0, 1, 0, 1, 5);
        tbl[32] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[33] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("rst_core_ready", 64'(bus.core_ready_o), 64'd1);
        chk("rst_acc_valid", 64'(bus.acc_valid_o), 64'd0);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_inflight", 64'(bus.inflight_o), 64'd0);
        chk("rst_empty", 64'(bus.empty_o), 64'd1);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_acc_rs1", bus.acc_rs1_o, 64'd0);

        // Directed table: rs1 = tag+2, rs2 = tag+4, ctl = 0
        for (int i = 0; i < 34; i++) begin
            e.rs1 = 64'(tbl[i].tag) + 64'd2;
            e.rs2 = 64'(tbl[i].tag) + 64'd4;
            e.ctl = 8'd0;
            e.tag = tbl[i].tag;
            drive(tbl[i].cv, e, tbl[i].rdy, tbl[i].done, tbl[i].fl);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_inflight", i), 64'(bus.inflight_o), 64'(tbl[i].e_inf));
            chk($sformatf("vec%0d_acc_valid", i), 64'(bus.acc_valid_o), 64'(tbl[i].e_val));
            chk($sformatf("vec%0d_full", i), 64'(bus.full_o), 64'(tbl[i].e_cnt == 4));
            chk($sformatf("vec%0d_core_ready", i), 64'(bus.core_ready_o), 64'(tbl[i].e_cnt != 4));
            chk($sformatf("vec%0d_empty", i), 64'(bus.empty_o), 64'(tbl[i].e_cnt == 0));
            if (tbl[i].e_val) begin
                chk($sformatf("vec%0d_tag", i), 64'(bus.acc_tag_o), 64'(tbl[i].e_tag));
                chk($sformatf("vec%0d_rs1", i), bus.acc_rs1_o, 64'(tbl[i].e_tag) + 64'd2);
                chk($sformatf("vec%0d_rs2", i), bus.acc_rs2_o, 64'(tbl[i].e_tag) + 64'd4);
                chk($sformatf("vec%0d_ctl", i), 64'(bus.acc_ctl_o), 64'd0);
            end
        end

        // Asynchronous reset in the middle of traffic
        e.rs1 = 64'hDEAD; e.rs2 = 64'hBEEF; e.ctl = 8'h5A; e.tag = 4'd9;
        drive(1'b1, e, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #2;
        drive(1'b0, e, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count_o), 64'd0);
        chk("arst_inflight", 64'(bus.inflight_o), 64'd0);
        chk("arst_acc_valid", 64'(bus.acc_valid_o), 64'd0);
        chk("arst_core_ready", 64'(bus.core_ready_o), 64'd1);
        chk("arst_acc_tag", 64'(bus.acc_tag_o), 64'd0);
        chk("arst_acc_rs1", bus.acc_rs1_o, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mq.delete();
        m_inf = 0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            logic cv, rdy, dn, fl;
            cv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            dn  = (m_inf > 0) ? logic'($urandom_range(0, 1)) : 1'b0;
            fl  = ($urandom_range(0, 39) == 0);
            step("rand", cv, rnd_ent(), rdy, dn, fl);
        end

        // Wrap-around: ten back-to-back push/pop pairs from an empty queue
        step("wrap_flush", 1'b0, rnd_ent(), 1'b0, 1'b0, 1'b1);
        dut_pops.delete();
        max_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            e = rnd_ent();
            e.tag = 4'(k);
            step("wrap", k < 10, e, 1'b1, m_inf > 0, 1'b0);
            if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
        end
        chk("wrap_pop_count", 64'(dut_pops.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < dut_pops.size()) chk($sformatf("wrap_order%0d", k), 64'(dut_pops[k]), 64'(k));
        end
        chk("wrap_max_count_le1", 64'(max_cnt <= 1), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
